// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Time-shares one external combinational ALU between two requesters.
//   Requests are arbitrated round-robin, the winning operands are registered
//   onto the ALU, the result is captured one cycle later and returned to the
//   winner over its own valid/ready response channel.
//
// Ports
//   clk, reset                  clock (rising edge), synchronous active-high reset
//   req{0,1}_valid/_ready       request handshake per requester
//   req{0,1}_op/_a/_b           opcode and operands per requester
//   rsp{0,1}_valid/_ready       response handshake per requester
//   rsp_data                    captured ALU result (shared by both responses)
//   busy                        high whenever an operation is in flight
//   alu_s/alu_a/alu_b           registered opcode/operands driven to the ALU
//   alu_r                       combinational result from the ALU
//   stat{0,1}_cnt               completed-response counters
//
// Build option
//   ALU_ARB_STATS_EN  when defined, stat{0,1}_cnt count response handshakes
//                     (wrapping); when undefined they are tied to zero.
//
// States
//   ST_IDLE | waiting for a request, arbitration active
//   ST_EXEC | ALU evaluating the registered operands
//   ST_RESP | result held on rsp_data until the owner takes it

module alu_share_arbiter #(
  parameter int DATA_W = 4,
  parameter int OP_W   = 3,
  parameter int RES_W  = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [OP_W-1:0]   req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [OP_W-1:0]   req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic              rsp0_valid,
  input  logic              rsp0_ready,
  output logic              rsp1_valid,
  input  logic              rsp1_ready,
  output logic [RES_W-1:0]  rsp_data,
  output logic              busy,
  output logic [OP_W-1:0]   alu_s,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  input  logic [RES_W-1:0]  alu_r,
  output logic [CNT_W-1:0]  stat0_cnt,
  output logic [CNT_W-1:0]  stat1_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  // Requester granted most recently; also identifies the owner of the
  // operation in flight, since it is only updated on a request handshake.
  logic                r_last_grant;
  logic [OP_W-1:0]     r_alu_s;
  logic [DATA_W-1:0]   r_alu_a;
  logic [DATA_W-1:0]   r_alu_b;
  logic [RES_W-1:0]    r_rsp_data;

  logic                w_grant;
  logic                w_req_hs;

  // Round-robin: on a tie the requester that did not win last time goes.
  always_comb begin
    w_grant = 1'b0;
    if (req0_valid && req1_valid) begin
      w_grant = ~r_last_grant;
    end else if (req1_valid) begin
      w_grant = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    rsp0_valid  = 1'b0;
    rsp1_valid  = 1'b0;
    w_req_hs    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Masked during reset so nothing is accepted on the reset edge.
        if (!reset) begin
          req0_ready = req0_valid && !w_grant;
          req1_ready = req1_valid && w_grant;
        end
        w_req_hs = req0_ready || req1_ready;
        if (w_req_hs) begin
          w_state_nxt = ST_EXEC;
        end
      end
      ST_EXEC: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        // An aborted result must never be seen as delivered.
        if (!reset) begin
          rsp0_valid = !r_last_grant;
          rsp1_valid = r_last_grant;
        end
        if ((rsp0_valid && rsp0_ready) || (rsp1_valid && rsp1_ready)) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_last_grant <= 1'b1;
      r_alu_s      <= '0;
      r_alu_a      <= '0;
      r_alu_b      <= '0;
      r_rsp_data   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_req_hs) begin
        r_last_grant <= w_grant;
        r_alu_s      <= w_grant ? req1_op : req0_op;
        r_alu_a      <= w_grant ? req1_a  : req0_a;
        r_alu_b      <= w_grant ? req1_b  : req0_b;
      end
      if (r_state == ST_EXEC) begin
        r_rsp_data <= alu_r;
      end
    end
  end

  assign busy     = (r_state != ST_IDLE);
  assign alu_s    = r_alu_s;
  assign alu_a    = r_alu_a;
  assign alu_b    = r_alu_b;
  assign rsp_data = r_rsp_data;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] r_stat0_cnt;
  logic [CNT_W-1:0] r_stat1_cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat0_cnt <= '0;
      r_stat1_cnt <= '0;
    end else begin
      if (rsp0_valid && rsp0_ready) begin
        r_stat0_cnt <= r_stat0_cnt + CNT_W'(1);
      end
      if (rsp1_valid && rsp1_ready) begin
        r_stat1_cnt <= r_stat1_cnt + CNT_W'(1);
      end
    end
  end

  assign stat0_cnt = r_stat0_cnt;
  assign stat1_cnt = r_stat1_cnt;
`else
  assign stat0_cnt = '0;
  assign stat1_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Testbench for alu_share_arbiter: directed scenarios plus a randomized run
// checked against a transaction-level model of the arbiter. The ALU is
// modelled here and driven from the DUT's alu_* outputs.

module tb_alu_share_arbiter;
  localparam int CNT_W = 4;
`ifdef ALU_ARB_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset;
  logic       req0_valid, req0_ready, req1_valid, req1_ready;
  logic [2:0] req0_op, req1_op;
  logic [3:0] req0_a, req0_b, req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [7:0] rsp_data;
  logic       busy;
  logic [2:0] alu_s;
  logic [3:0] alu_a, alu_b;
  logic [7:0] alu_r;
  logic [CNT_W-1:0] stat0_cnt, stat1_cnt;

  int errors = 0;
  int checks = 0;
  int exp_s0 = 0;
  int exp_s1 = 0;
  logic [2:0] last_s;
  logic [3:0] last_a, last_b;

  always #5 clk = ~clk;

  alu_share_arbiter #(.DATA_W(4), .OP_W(3), .RES_W(8), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
    .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
    .req1_a(req1_a), .req1_b(req1_b),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_data(rsp_data), .busy(busy),
    .alu_s(alu_s), .alu_a(alu_a), .alu_b(alu_b), .alu_r(alu_r),
    .stat0_cnt(stat0_cnt), .stat1_cnt(stat1_cnt)
  );

  // ALU: 0 ADD, 1 SUB, 2 AND, 3 MUL, 4 OR, 5 INC, 6 XOR, 7 NOT.
  // Non-multiply results are 4 bits zero-filled to 8.
  function automatic logic [7:0] alu_fn(input logic [2:0] op, input logic [3:0] a,
                                        input logic [3:0] b);
    logic [3:0] n;
    n = 4'h0;
    case (op)
      3'd0: n = a + b;
      3'd1: n = a - b;
      3'd2: n = a & b;
      3'd3: return {4'h0, a} * {4'h0, b};
      3'd4: n = a | b;
      3'd5: n = a + 4'd1;
      3'd6: n = a ^ b;
      default: n = ~a;
    endcase
    return {4'h0, n};
  endfunction

  always_comb alu_r = alu_fn(alu_s, alu_a, alu_b);

  function automatic logic [CNT_W-1:0] stat_exp(input int n);
    if (!STATS) return '0;
    return CNT_W'(n % (1 << CNT_W));
  endfunction

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle_inputs();
    req0_valid = 1'b0; req1_valid = 1'b0;
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle_inputs();
    tick();
    tick();
    reset = 1'b0;
    exp_s0 = 0; exp_s1 = 0;
    last_s = '0; last_a = '0; last_b = '0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req0_valid = 1'b1; req1_valid = 1'b1; rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_op = 3'd0; req0_a = 4'd1; req0_b = 4'd1;
    req1_op = 3'd0; req1_a = 4'd2; req1_b = 4'd2;
    tick();
    tick();
    #1;
    checks++; if (req0_ready !== 1'b0) begin errors++; $display("FAIL reset_req0_ready got %0b want 0", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL reset_req1_ready got %0b want 0", req1_ready); end
    checks++; if (rsp0_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp0_valid got %0b want 0", rsp0_valid); end
    checks++; if (rsp1_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp1_valid got %0b want 0", rsp1_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
    checks++; if (rsp_data !== 8'h00) begin errors++; $display("FAIL reset_rsp_data got %0h want 0", rsp_data); end
    checks++; if ({alu_s, alu_a, alu_b} !== 11'h0) begin errors++; $display("FAIL reset_alu_regs got %0h/%0h/%0h want 0", alu_s, alu_a, alu_b); end
    checks++; if (stat0_cnt !== '0 || stat1_cnt !== '0) begin errors++; $display("FAIL reset_stats got %0d/%0d want 0/0", stat0_cnt, stat1_cnt); end
    reset = 1'b0;
    idle_inputs();
    exp_s0 = 0; exp_s1 = 0;
    last_s = '0; last_a = '0; last_b = '0;
  endtask

  task automatic test_single_mul();
    tick();
    req0_valid = 1'b1; req0_op = 3'b011; req0_a = 4'd3; req0_b = 4'd5; rsp0_ready = 1'b1;
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL mul_req0_ready got %0b want 1", req0_ready); end
    checks++; if (req1_ready !== 1'b0) begin errors++; $display("FAIL mul_req1_ready got %0b want 0", req1_ready); end
    tick();
    req0_valid = 1'b0; req0_a = 4'hA; req0_b = 4'hA;
    #1;
    checks++; if (busy !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL mul_exec got busy=%0b rsp0_valid=%0b want 1/0", busy, rsp0_valid); end
    checks++; if ({alu_s, alu_a, alu_b} !== {3'd3, 4'd3, 4'd5}) begin errors++; $display("FAIL mul_alu_regs got %0h/%0h/%0h want 3/3/5", alu_s, alu_a, alu_b); end
    tick();
    #1;
    checks++; if (rsp0_valid !== 1'b1 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL mul_rsp_valid got %0b%0b want rsp0=1 rsp1=0", rsp0_valid, rsp1_valid); end
    checks++; if (rsp_data !== 8'h0F) begin errors++; $display("FAIL mul_rsp_data got %0h want 0f", rsp_data); end
    tick();
    #1;
    checks++; if (busy !== 1'b0 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL mul_release got busy=%0b rsp0_valid=%0b want 0/0", busy, rsp0_valid); end
    exp_s0++;
    last_s = 3'd3; last_a = 4'd3; last_b = 4'd5;
    rsp0_ready = 1'b0;
  endtask

  task automatic test_contention();
    int g;
    logic [7:0] e;
    do_reset();
    rsp0_ready = 1'b1; rsp1_ready = 1'b1;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd4; req0_b = 4'd3;
    req1_valid = 1'b1; req1_op = 3'd1; req1_a = 4'd9; req1_b = 4'd2;
    g = 0;
    for (int k = 0; k < 12; k++) begin
      #1;
      checks++; if ({req1_ready, req0_ready} !== ((g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_grant op %0d got ready1/0=%0b%0b want grant %0d", k, req1_ready, req0_ready, g); end
      if (k < 2) e = 8'h07;
      else e = (g == 1) ? alu_fn(req1_op, req1_a, req1_b) : alu_fn(req0_op, req0_a, req0_b);
      if (g == 1) begin last_s = req1_op; last_a = req1_a; last_b = req1_b; end
      else begin last_s = req0_op; last_a = req0_a; last_b = req0_b; end
      tick();
      if (g == 1) begin req1_op = 3'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom); end
      else begin req0_op = 3'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom); end
      tick();
      #1;
      checks++; if ({rsp1_valid, rsp0_valid} !== ((g == 1) ? 2'b10 : 2'b01)) begin errors++; $display("FAIL contention_rsp_valid op %0d got %0b%0b want owner %0d", k, rsp1_valid, rsp0_valid, g); end
      checks++; if (rsp_data !== e) begin errors++; $display("FAIL contention_rsp_data op %0d got %0h want %0h", k, rsp_data, e); end
      tick();
      if (g == 1) exp_s1++; else exp_s0++;
      g = 1 - g;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [3:0] b;
    b = 4'($urandom);
    rsp0_ready = 1'b0; rsp1_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'b101; req1_a = 4'hE; req1_b = b;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL bp_req1_ready got %0b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    req0_valid = 1'b1; req0_op = 3'd0; req0_a = 4'd1; req0_b = 4'd1; rsp0_ready = 1'b1;
    tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      checks++; if (rsp1_valid !== 1'b1 || rsp0_valid !== 1'b0) begin errors++; $display("FAIL bp_rsp_valid cycle %0d got rsp1=%0b rsp0=%0b want 1/0", i, rsp1_valid, rsp0_valid); end
      checks++; if (rsp_data !== 8'h0F) begin errors++; $display("FAIL bp_rsp_data cycle %0d got %0h want 0f", i, rsp_data); end
      checks++; if (busy !== 1'b1 || req0_ready !== 1'b0) begin errors++; $display("FAIL bp_busy_ready cycle %0d got busy=%0b req0_ready=%0b want 1/0", i, busy, req0_ready); end
      tick();
    end
    rsp1_ready = 1'b1;
    #1;
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL bp_before_release got %0b want 1", rsp1_valid); end
    tick();
    #1;
    checks++; if (busy !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL bp_release got busy=%0b rsp1_valid=%0b want 0/0", busy, rsp1_valid); end
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL bp_idle_req0_ready got %0b want 1", req0_ready); end
    idle_inputs();
    exp_s1++;
    last_s = 3'b101; last_a = 4'hE; last_b = b;
  endtask

  task automatic test_reset_mid();
    tick();
    req0_valid = 1'b1; req0_op = 3'd3; req0_a = 4'd7; req0_b = 4'd9; rsp0_ready = 1'b0;
    tick();
    req0_valid = 1'b0; reset = 1'b1;
    tick();
    reset = 1'b0;
    exp_s0 = 0; exp_s1 = 0; last_s = '0; last_a = '0; last_b = '0;
    #1;
    checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rst_exec_flags got busy/rsp0/rsp1=%0b%0b%0b want 000", busy, rsp0_valid, rsp1_valid); end
    checks++; if (rsp_data !== 8'h00 || {alu_s, alu_a, alu_b} !== 11'h0) begin errors++; $display("FAIL rst_exec_data got rsp=%0h alu=%0h/%0h/%0h want 0", rsp_data, alu_s, alu_a, alu_b); end
    checks++; if (stat0_cnt !== '0 || stat1_cnt !== '0) begin errors++; $display("FAIL rst_exec_stats got %0d/%0d want 0/0", stat0_cnt, stat1_cnt); end
    rsp0_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      #1;
      checks++; if (rsp0_valid !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rst_exec_no_rsp cycle %0d got rsp0=%0b busy=%0b want 0/0", i, rsp0_valid, busy); end
    end
    rsp0_ready = 1'b0;
    req1_valid = 1'b1; req1_op = 3'd2; req1_a = 4'hF; req1_b = 4'h3; rsp1_ready = 1'b0;
    #1;
    checks++; if (req1_ready !== 1'b1) begin errors++; $display("FAIL rst_resp_accept got %0b want 1", req1_ready); end
    tick();
    req1_valid = 1'b0;
    tick();
    #1;
    checks++; if (rsp1_valid !== 1'b1) begin errors++; $display("FAIL rst_resp_reached got %0b want 1", rsp1_valid); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rst_resp_flags got busy/rsp0/rsp1=%0b%0b%0b want 000", busy, rsp0_valid, rsp1_valid); end
    checks++; if (rsp_data !== 8'h00 || {alu_s, alu_a, alu_b} !== 11'h0) begin errors++; $display("FAIL rst_resp_data got rsp=%0h alu=%0h/%0h/%0h want 0", rsp_data, alu_s, alu_a, alu_b); end
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin errors++; $display("FAIL rst_first_tie got ready1/0=%0b%0b want 01", req1_ready, req0_ready); end
    idle_inputs();
  endtask

  task automatic test_isolation();
    logic [7:0] e;
    for (int i = 0; i < 4; i++) begin
      tick();
      req0_valid = 1'b0; req0_a = 4'($urandom); req0_b = 4'($urandom);
      #1;
      checks++; if (req0_ready !== 1'b0 || alu_a !== last_a || alu_b !== last_b) begin errors++; $display("FAIL iso_idle cycle %0d got ready=%0b alu_a=%0h alu_b=%0h want 0/%0h/%0h", i, req0_ready, alu_a, alu_b, last_a, last_b); end
    end
    tick();
    req0_valid = 1'b1; req0_op = 3'd6; req0_a = 4'h6; req0_b = 4'h3; rsp0_ready = 1'b0;
    e = alu_fn(3'd6, 4'h6, 4'h3);
    #1;
    checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL iso_accept got %0b want 1", req0_ready); end
    for (int i = 0; i < 4; i++) begin
      tick();
      req0_a = 4'($urandom); req0_b = 4'($urandom);
      #1;
      checks++; if (alu_a !== 4'h6 || alu_b !== 4'h3) begin errors++; $display("FAIL iso_alu_regs cycle %0d got %0h/%0h want 6/3", i, alu_a, alu_b); end
      if (i >= 1) begin
        checks++; if (rsp0_valid !== 1'b1 || rsp_data !== e) begin errors++; $display("FAIL iso_rsp cycle %0d got valid=%0b data=%0h want 1/%0h", i, rsp0_valid, rsp_data, e); end
      end
    end
    req0_valid = 1'b0; rsp0_ready = 1'b1;
    tick();
    #1;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL iso_release got busy=%0b want 0", busy); end
    exp_s0++;
    last_s = 3'd6; last_a = 4'h6; last_b = 4'h3;
    rsp0_ready = 1'b0;
  endtask

  task automatic test_stats();
    do_reset();
    rsp0_ready = 1'b1;
    for (int n = 0; n < 17; n++) begin
      req0_valid = 1'b1; req0_op = 3'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      #1;
      checks++; if (req0_ready !== 1'b1) begin errors++; $display("FAIL stats_accept op %0d got %0b want 1", n, req0_ready); end
      last_s = req0_op; last_a = req0_a; last_b = req0_b;
      tick();
      req0_valid = 1'b0;
      tick();
      tick();
      exp_s0++;
    end
    #1;
    checks++; if (stat0_cnt !== stat_exp(exp_s0)) begin errors++; $display("FAIL stats_stat0 got %0d want %0d", stat0_cnt, stat_exp(exp_s0)); end
    checks++; if (stat1_cnt !== '0) begin errors++; $display("FAIL stats_stat1 got %0d want 0", stat1_cnt); end
    idle_inputs();
  endtask

  // Transaction-level model: an accepted op becomes a pending response for
  // its owner, visible two cycles after the accept cycle and held until the
  // owner's rsp_ready; grants alternate on ties.
  task automatic test_random();
    int age, owner, m_last, g;
    logic [7:0] m_exp;
    do_reset();
    age = -1; owner = 0; m_last = 1; m_exp = '0;
    for (int c = 0; c < 400; c++) begin
      req0_valid = ($urandom % 3) != 0; req1_valid = ($urandom % 3) != 0;
      req0_op = 3'($urandom); req0_a = 4'($urandom); req0_b = 4'($urandom);
      req1_op = 3'($urandom); req1_a = 4'($urandom); req1_b = 4'($urandom);
      rsp0_ready = 1'($urandom); rsp1_ready = 1'($urandom);
      #1;
      checks++; if (stat0_cnt !== stat_exp(exp_s0) || stat1_cnt !== stat_exp(exp_s1)) begin errors++; $display("FAIL rand_stats cycle %0d got %0d/%0d want %0d/%0d", c, stat0_cnt, stat1_cnt, stat_exp(exp_s0), stat_exp(exp_s1)); end
      if (age < 0) begin
        g = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
        checks++; if (req0_ready !== (req0_valid && g == 0) || req1_ready !== (req1_valid && g == 1)) begin errors++; $display("FAIL rand_grant cycle %0d got ready1/0=%0b%0b want grant %0d v=%0b%0b", c, req1_ready, req0_ready, g, req1_valid, req0_valid); end
        checks++; if ({busy, rsp0_valid, rsp1_valid} !== 3'b000) begin errors++; $display("FAIL rand_idle cycle %0d got busy/rsp0/rsp1=%0b%0b%0b want 000", c, busy, rsp0_valid, rsp1_valid); end
        checks++; if ({alu_s, alu_a, alu_b} !== {last_s, last_a, last_b}) begin errors++; $display("FAIL rand_alu_hold cycle %0d got %0h/%0h/%0h want %0h/%0h/%0h", c, alu_s, alu_a, alu_b, last_s, last_a, last_b); end
        if (req0_valid || req1_valid) begin
          owner = g; m_last = g;
          if (g == 1) begin last_s = req1_op; last_a = req1_a; last_b = req1_b; end
          else begin last_s = req0_op; last_a = req0_a; last_b = req0_b; end
          m_exp = alu_fn(last_s, last_a, last_b);
          age = 1;
        end
      end else begin
        checks++; if (req0_ready !== 1'b0 || req1_ready !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL rand_busy cycle %0d got ready1/0=%0b%0b busy=%0b want 00/1", c, req1_ready, req0_ready, busy); end
        checks++; if ({alu_s, alu_a, alu_b} !== {last_s, last_a, last_b}) begin errors++; $display("FAIL rand_alu_regs cycle %0d got %0h/%0h/%0h want %0h/%0h/%0h", c, alu_s, alu_a, alu_b, last_s, last_a, last_b); end
        if (age == 1) begin
          checks++; if (rsp0_valid !== 1'b0 || rsp1_valid !== 1'b0) begin errors++; $display("FAIL rand_early_rsp cycle %0d got %0b%0b want 00", c, rsp1_valid, rsp0_valid); end
          age = 2;
        end else begin
          checks++; if (rsp0_valid !== (owner == 0) || rsp1_valid !== (owner == 1)) begin errors++; $display("FAIL rand_rsp_valid cycle %0d got rsp1/0=%0b%0b want owner %0d", c, rsp1_valid, rsp0_valid, owner); end
          checks++; if (rsp_data !== m_exp) begin errors++; $display("FAIL rand_rsp_data cycle %0d got %0h want %0h", c, rsp_data, m_exp); end
          if ((owner == 0 && rsp0_ready) || (owner == 1 && rsp1_ready)) begin
            if (owner == 1) exp_s1++; else exp_s0++;
            age = -1;
          end else begin
            age++;
          end
        end
      end
      tick();
    end
    idle_inputs();
  endtask

  initial begin
    reset = 1'b1;
    idle_inputs();
    req0_op = '0; req0_a = '0; req0_b = '0;
    req1_op = '0; req1_a = '0; req1_b = '0;
    test_reset();
    test_single_mul();
    test_contention();
    test_backpressure();
    test_reset_mid();
    test_isolation();
    test_stats();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
